// File: rtl/packet_stream_fifo.sv
// Packet stream FIFO between the packet controller and the Edge-PE dispatch logic.
// Provides full / hysteresis stall back-pressure and a valid/ready output, oldest first.
`ifndef PACKET_SIZE
`define PACKET_SIZE 32
`endif

module packet_stream_fifo #(
   parameter int PACKET_W = `PACKET_SIZE,
   parameter int DEPTH    = 8,
   parameter int STALL_HI = 6,
   parameter int STALL_LO = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [PACKET_W-1:0]        packet_in,
   input  logic                       replay_iter_flag,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [PACKET_W-1:0]        out_packet,
   output logic                       full,
   output logic                       fifo_stall,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0] FULL_C     = CW'(DEPTH - 1);
   localparam logic [CW-1:0] STALL_HI_C = CW'(STALL_HI);
   localparam logic [CW-1:0] STALL_LO_C = CW'(STALL_LO);
   localparam logic [CW-1:0] ZERO_C     = {CW{1'b0}};

   localparam logic [0:0] ST_NORMAL  = 1'b0;
   localparam logic [0:0] ST_STALLED = 1'b1;

   logic [PACKET_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]       rd_ptr_r;
   logic [AW-1:0]       wr_ptr_r;
   logic [CW-1:0]       count_r;
   logic [CW-1:0]       next_count_s;
   logic [0:0]          state_r;
   logic [0:0]          next_state_s;
   logic                overflow_r;
   logic                pop_s;
   logic                push_s;
   logic                drop_s;

   // Handshake decode: a push at DEPTH is accepted only when a pop frees a slot.
   always_comb begin
      pop_s  = (count_r != ZERO_C) && out_ready;
      push_s = wr_en && ((count_r != DEPTH_C) || pop_s);
      drop_s = wr_en && (count_r == DEPTH_C) && !pop_s;
   end

   // Post-update occupancy and stall FSM transition.
   always_comb begin
      next_count_s = count_r;
      next_state_s = state_r;
      if (replay_iter_flag) begin
         next_count_s = ZERO_C;
      end else begin
         case ({push_s, pop_s})
            2'b10:   next_count_s = count_r + CW'(1);
            2'b01:   next_count_s = count_r - CW'(1);
            default: next_count_s = count_r;
         endcase
      end
      case (state_r)
         ST_NORMAL: begin
            if (next_count_s >= STALL_HI_C) next_state_s = ST_STALLED;
            else                            next_state_s = ST_NORMAL;
         end
         ST_STALLED: begin
            if (next_count_s <= STALL_LO_C) next_state_s = ST_NORMAL;
            else                            next_state_s = ST_STALLED;
         end
         default: next_state_s = ST_NORMAL;
      endcase
   end

   // Pointers, occupancy, stall state and sticky overflow flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         count_r    <= ZERO_C;
         state_r    <= ST_NORMAL;
         overflow_r <= 1'b0;
      end else if (replay_iter_flag) begin
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         count_r    <= ZERO_C;
         state_r    <= ST_NORMAL;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         count_r    <= next_count_s;
         state_r    <= next_state_s;
         overflow_r <= overflow_r | drop_s;
      end
   end

   // Packet storage; contents are irrelevant once the pointers are cleared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= {PACKET_W{1'b0}};
      end else if (push_s && !replay_iter_flag) begin
         mem_r[wr_ptr_r] <= packet_in;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // One slot of slack in full covers the read already in flight at the controller.
   always_comb begin
      out_valid    = (count_r != ZERO_C);
      out_packet   = out_valid ? mem_r[rd_ptr_r] : {PACKET_W{1'b0}};
      full         = (count_r >= FULL_C);
      fifo_stall   = (state_r == ST_STALLED);
      count        = count_r;
      overflow_err = overflow_r;
   end

endmodule
